sqrt_detector_param: RTL

Parametrised perfect-square detector. It is the next generation of the square-root detector control/datapath pair, with generalised operand width, a start/done handshake, and the root and remainder brought out. On `Go` it captures a WIDTH-bit unsigned operand and computes floor(sqrt(in)) by restoring binary (digit-by-digit) square root, one root bit per cycle. It flags whether the operand is a perfect square. It sits between operand producer and result consumer as a single-clock, multi-cycle functional unit.

---
 rtl/sqrt_detector_param.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sqrt_detector_param.sv
// Multi-cycle perfect-square detector: restoring digit-by-digit square root,
// one root bit per cycle, with start/done handshake and root/remainder outputs.
module sqrt_detector_param #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Go,
  input  logic [WIDTH-1:0]   in,
  output logic               busy,
  output logic               over,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   rem,
  output logic               is_square
);

  localparam int HALF = WIDTH / 2;
  localparam int RW   = HALF + 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("sqrt_detector_param: WIDTH must be even and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] op;
  logic [RW-1:0]    r;
  logic [HALF-1:0]  q;
  logic [CW-1:0]    cnt;

  logic [RW-1:0]    r_sh;
  logic [RW-1:0]    t;
  logic [RW-1:0]    r_new;
  logic [HALF-1:0]  q_new;
  logic             ge;
  logic             accept;
  logic             last;

  // The remainder never exceeds 2q, so the bits shifted out of r are always zero.
  always_comb begin
    r_sh  = RW'({r, op[WIDTH-1 -: 2]});
    t     = {q, 2'b01};
    ge    = (r_sh >= t);
    r_new = ge ? (r_sh - t) : r_sh;
    q_new = (q << 1) | HALF'(ge);
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (Go) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (Go) begin
          accept     = 1'b1;
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op        <= '0;
      r         <= '0;
      q         <= '0;
      cnt       <= '0;
      root      <= '0;
      rem       <= '0;
      is_square <= 1'b0;
    end else if (accept) begin
      op  <= in;
      r   <= '0;
      q   <= '0;
      cnt <= CW'(HALF - 1);
    end else if (state == CALC) begin
      op <= op << 2;
      r  <= r_new;
      q  <= q_new;
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (last) begin
        root      <= q_new;
        rem       <= r_new[HALF:0];
        is_square <= (r_new == '0);
      end
    end
  end

  assign busy = (state == CALC);
  assign over = (state == DONE);

endmodule
